// File: rtl/input_vc_router.sv
// -----------------------------------------------------------------------------
// ravenoc_pkg / input_vc_router
//
// Receive side of a RaveNoC router port. Incoming flits are buffered in one
// FIFO per virtual channel. Each VC computes an XY route from the head flit at
// its FIFO head and holds that route until the tail flit leaves. Every VC with
// a route is offered to the matching output slot. Each slot picks one VC by
// fixed priority. U-turn packets and orphan body/tail flits are discarded.
//
// Ports
//   clk          single clock
//   arst         synchronous active-high reset
//   fin_req_i    flit from the link (valid, vc_id, fdata)
//   fin_resp_o   ready back to the link
//   fout_req_o   flits to the four other output modules; slot k is the k-th
//                direction of {L,N,S,W,E}, ascending, skipping IN_DIR
//   fout_resp_i  ready from each output module
//   err_o        high in any cycle in which a flit is discarded
//   pkt_cnt_o    (RAVENOC_IN_STATS_EN only) count of forwarded packets
//
// Optional build macro: RAVENOC_IN_STATS_EN adds the packet counter.
// -----------------------------------------------------------------------------
package ravenoc_pkg;
    localparam int N_VIRT_CHN    = 2;
    localparam int VC_WIDTH      = 1;
    localparam bit H_PRIORITY    = 1'b1;
    localparam int MIN_SIZE_FLIT = 1;
    localparam int FLIT_WIDTH    = 32;
    localparam int X_WIDTH       = 2;
    localparam int Y_WIDTH       = 2;
    localparam int PKT_WIDTH     = 8;

    // Header field positions. The order matches s_flit_head_data_t.
    localparam int TYPE_MSB = FLIT_WIDTH - 1;
    localparam int X_MSB    = FLIT_WIDTH - 3;
    localparam int Y_MSB    = X_MSB - X_WIDTH;
    localparam int SIZE_MSB = Y_MSB - Y_WIDTH;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } flit_type_t;

    typedef enum logic [2:0] {
        LOCAL_PORT = 3'd0,
        NORTH_PORT = 3'd1,
        SOUTH_PORT = 3'd2,
        WEST_PORT  = 3'd3,
        EAST_PORT  = 3'd4
    } router_dir_t;

    typedef struct packed {
        flit_type_t                                          flit_type;
        logic [X_WIDTH-1:0]                                  x_dest;
        logic [Y_WIDTH-1:0]                                  y_dest;
        logic [PKT_WIDTH-1:0]                                pkt_size;
        logic [FLIT_WIDTH-3-X_WIDTH-Y_WIDTH-PKT_WIDTH:0]     data;
    } s_flit_head_data_t;

    typedef struct packed {
        flit_type_t              flit_type;
        logic [FLIT_WIDTH-3:0]   data;
    } s_flit_data_t;

    typedef struct packed {
        logic                    valid;
        logic [VC_WIDTH-1:0]     vc_id;
        logic [FLIT_WIDTH-1:0]   fdata;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;
endpackage

module input_vc_router
    import ravenoc_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [X_WIDTH-1:0] ROUTER_X   = '0,
    parameter logic [Y_WIDTH-1:0] ROUTER_Y   = '0,
    parameter int unsigned        IN_DIR     = 0
) (
    input  logic               clk,
    input  logic               arst,
    input  s_flit_req_t        fin_req_i,
    output s_flit_resp_t       fin_resp_o,
    output s_flit_req_t  [3:0] fout_req_o,
    input  s_flit_resp_t [3:0] fout_resp_i,
    output logic               err_o
`ifdef RAVENOC_IN_STATS_EN
    ,
    output logic [15:0]        pkt_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  IN_PORT = IN_DIR[2:0];

    typedef enum logic {
        VC_IDLE,
        VC_ACTIVE
    } vc_state_t;

    logic [FLIT_WIDTH-1:0] mem [N_VIRT_CHN][FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr [N_VIRT_CHN];
    logic [PTR_W:0]        rd_ptr [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] empty;
    logic [N_VIRT_CHN-1:0] full;
    logic                  push_en;

    logic [FLIT_WIDTH-1:0] head      [N_VIRT_CHN];
    flit_type_t            ftype     [N_VIRT_CHN];
    logic [1:0]            cur_route [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] is_single;
    logic [N_VIRT_CHN-1:0] route_ok;
    logic [N_VIRT_CHN-1:0] discard;
    logic [N_VIRT_CHN-1:0] pop_fwd;
    logic [N_VIRT_CHN-1:0] pop;

    vc_state_t             state_q    [N_VIRT_CHN];
    vc_state_t             state_next [N_VIRT_CHN];
    logic [1:0]            route_q    [N_VIRT_CHN];
    logic [1:0]            route_next [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] drop_q;
    logic [N_VIRT_CHN-1:0] drop_next;

    logic [3:0]            win_ok;
    logic [VC_WIDTH-1:0]   win_vc [4];

    function automatic router_dir_t xy_route(input logic [X_WIDTH-1:0] x,
                                             input logic [Y_WIDTH-1:0] y);
        if (x > ROUTER_X)      return EAST_PORT;
        else if (x < ROUTER_X) return WEST_PORT;
        else if (y > ROUTER_Y) return SOUTH_PORT;
        else if (y < ROUTER_Y) return NORTH_PORT;
        else                   return LOCAL_PORT;
    endfunction

    // The own direction is never a slot, so directions above it shift down.
    function automatic logic [1:0] dir_to_slot(input logic [2:0] d);
        if (d < IN_PORT) return d[1:0];
        else             return 2'(d - 3'd1);
    endfunction

    // With H_PRIORITY the scan runs upward, so the highest VC is written last
    // and wins. Otherwise the scan runs downward and the lowest VC wins.
    function automatic int unsigned arb_idx(input int unsigned i);
        if (H_PRIORITY) return i;
        else            return N_VIRT_CHN - 1 - i;
    endfunction

    // ------------------------------------------------------------------ push
    assign fin_resp_o.ready = ~full[fin_req_i.vc_id] & ~arst;
    assign push_en          = fin_req_i.valid & fin_resp_o.ready;

    always_comb begin
        for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
            empty[v] = (wr_ptr[v] == rd_ptr[v]);
            full[v]  = (wr_ptr[v][PTR_W] != rd_ptr[v][PTR_W]) &&
                       (wr_ptr[v][PTR_W-1:0] == rd_ptr[v][PTR_W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en)
            mem[fin_req_i.vc_id][wr_ptr[fin_req_i.vc_id][PTR_W-1:0]] <= fin_req_i.fdata;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
                if (push_en && fin_req_i.vc_id == VC_WIDTH'(v))
                    wr_ptr[v] <= wr_ptr[v] + {{PTR_W{1'b0}}, 1'b1};
                if (pop[v])
                    rd_ptr[v] <= rd_ptr[v] + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------- per-VC route / discard
    always_comb begin
        route_ok  = '0;
        discard   = '0;
        is_single = '0;
        for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
            head[v]      = mem[v][rd_ptr[v][PTR_W-1:0]];
            ftype[v]     = flit_type_t'(head[v][TYPE_MSB -: 2]);
            is_single[v] = (head[v][SIZE_MSB -: PKT_WIDTH] == PKT_WIDTH'(MIN_SIZE_FLIT));
            cur_route[v] = route_q[v];
            if (!empty[v]) begin
                if (state_q[v] == VC_ACTIVE) begin
                    if (drop_q[v]) discard[v]  = 1'b1;
                    else           route_ok[v] = 1'b1;
                end else if (ftype[v] == HEAD_FLIT) begin
                    if (xy_route(head[v][X_MSB -: X_WIDTH], head[v][Y_MSB -: Y_WIDTH]) == IN_PORT) begin
                        discard[v] = 1'b1;
                    end else begin
                        route_ok[v]  = 1'b1;
                        cur_route[v] = dir_to_slot(xy_route(head[v][X_MSB -: X_WIDTH],
                                                            head[v][Y_MSB -: Y_WIDTH]));
                    end
                end else begin
                    discard[v] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------- output select
    always_comb begin
        win_ok     = '0;
        fout_req_o = '0;
        pop_fwd    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            win_vc[k] = '0;
            for (int unsigned i = 0; i < N_VIRT_CHN; i++) begin
                if (route_ok[arb_idx(i)] && cur_route[arb_idx(i)] == 2'(k)) begin
                    win_ok[k] = 1'b1;
                    win_vc[k] = VC_WIDTH'(arb_idx(i));
                end
            end
            if (win_ok[k]) begin
                fout_req_o[k].valid = 1'b1;
                fout_req_o[k].vc_id = win_vc[k];
                fout_req_o[k].fdata = head[win_vc[k]];
                if (fout_resp_i[k].ready)
                    pop_fwd[win_vc[k]] = 1'b1;
            end
        end
    end

    assign pop   = pop_fwd | discard;
    assign err_o = |discard;

    // ------------------------------------------------------------ VC FSMs
    always_comb begin
        for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
            state_next[v] = state_q[v];
            route_next[v] = route_q[v];
        end
        drop_next = drop_q;
        for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
            if (pop[v]) begin
                case (state_q[v])
                    VC_IDLE: begin
                        // Only a multi-flit head opens a lock. A discarded head
                        // locks with the drop flag so its body follows it out.
                        if (ftype[v] == HEAD_FLIT && !is_single[v]) begin
                            state_next[v] = VC_ACTIVE;
                            route_next[v] = cur_route[v];
                            drop_next[v]  = discard[v];
                        end
                    end
                    VC_ACTIVE: begin
                        if (ftype[v] == TAIL_FLIT) begin
                            state_next[v] = VC_IDLE;
                            drop_next[v]  = 1'b0;
                        end
                    end
                    default: state_next[v] = VC_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
                state_q[v] <= VC_IDLE;
                route_q[v] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
                state_q[v] <= state_next[v];
                route_q[v] <= route_next[v];
            end
            drop_q <= drop_next;
        end
    end

`ifdef RAVENOC_IN_STATS_EN
    logic [15:0] pkt_inc;
    logic [15:0] pkt_cnt;

    always_comb begin
        pkt_inc = '0;
        for (int unsigned v = 0; v < N_VIRT_CHN; v++) begin
            if (pop_fwd[v] &&
                ((state_q[v] == VC_ACTIVE && ftype[v] == TAIL_FLIT) ||
                 (state_q[v] == VC_IDLE && ftype[v] == HEAD_FLIT && is_single[v])))
                pkt_inc = pkt_inc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) pkt_cnt <= '0;
        else      pkt_cnt <= pkt_cnt + pkt_inc;
    end

    assign pkt_cnt_o = pkt_cnt;
`endif

endmodule

// File: tb/tb_input_vc_router.sv
// -----------------------------------------------------------------------------
// tb_input_vc_router
// Scoreboard bench for input_vc_router. DUT: IN_DIR=WEST, router (1,1),
// FIFO_DEPTH=2. The stimulus pushes the expected output flits per slot and a
// count of expected err_o pulses. A negedge monitor pops and compares on
// every slot transfer (valid && ready) and on every err_o cycle.
// Slot map for IN_DIR=WEST: 0=LOCAL 1=NORTH 2=SOUTH 3=EAST.
// -----------------------------------------------------------------------------
module tb_input_vc_router;
    import ravenoc_pkg::*;

    typedef struct packed {
        logic [VC_WIDTH-1:0]   vc;
        logic [FLIT_WIDTH-1:0] fdata;
    } exp_t;

    logic               clk;
    logic               arst;
    s_flit_req_t        fin_req;
    s_flit_resp_t       fin_resp;
    s_flit_req_t  [3:0] fout_req;
    s_flit_resp_t [3:0] fout_resp;
    logic               err;
`ifdef RAVENOC_IN_STATS_EN
    logic [15:0]        pkt_cnt;
`endif

    exp_t exp_q [4][$];
    int   exp_err;
    int   checks;
    int   errors;
    exp_t mon_e;

    input_vc_router #(
        .FIFO_DEPTH (2),
        .ROUTER_X   (2'd1),
        .ROUTER_Y   (2'd1),
        .IN_DIR     (3)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req),
        .fin_resp_o  (fin_resp),
        .fout_req_o  (fout_req),
        .fout_resp_i (fout_resp),
        .err_o       (err)
`ifdef RAVENOC_IN_STATS_EN
        ,
        .pkt_cnt_o   (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

    function automatic logic [FLIT_WIDTH-1:0] mk_head(input logic [1:0] x, input logic [1:0] y,
                                                     input logic [7:0] size, input logic [17:0] d);
        s_flit_head_data_t h;
        h.flit_type = HEAD_FLIT;
        h.x_dest    = x;
        h.y_dest    = y;
        h.pkt_size  = size;
        h.data      = d;
        return h;
    endfunction

    function automatic logic [FLIT_WIDTH-1:0] mk_data(input flit_type_t t, input logic [29:0] d);
        s_flit_data_t f;
        f.flit_type = t;
        f.data      = d;
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int slot, input logic [VC_WIDTH-1:0] vc, input logic [FLIT_WIDTH-1:0] d);
        exp_t e;
        e.vc    = vc;
        e.fdata = d;
        exp_q[slot].push_back(e);
    endtask

    // Holds the flit on the link until it is accepted. Returns 1 time unit
    // after the accepting edge.
    task automatic push(input logic [VC_WIDTH-1:0] vc, input logic [FLIT_WIDTH-1:0] d);
        bit ok;
        ok            = 1'b0;
        fin_req.valid = 1'b1;
        fin_req.vc_id = vc;
        fin_req.fdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (fin_resp.ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual ready=0 required ready=1 vc %0d", vc);
        end
        @(posedge clk);
        #1;
        fin_req.valid = 1'b0;
    endtask

    function automatic logic [3:0] valids();
        return {fout_req[3].valid, fout_req[2].valid, fout_req[1].valid, fout_req[0].valid};
    endfunction

    task automatic set_rdy(input logic [3:0] r);
        for (int k = 0; k < 4; k++) fout_resp[k].ready = r[k];
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!arst) begin
            for (int k = 0; k < 4; k++) begin
                if (fout_req[k].valid && fout_resp[k].ready) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out slot %0d actual vc %0d data %0h required none",
                                 k, fout_req[k].vc_id, fout_req[k].fdata);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        if (fout_req[k].vc_id !== mon_e.vc || fout_req[k].fdata !== mon_e.fdata) begin
                            errors++;
                            $display("FAIL out_slot%0d actual vc %0d data %0h required vc %0d data %0h",
                                     k, fout_req[k].vc_id, fout_req[k].fdata, mon_e.vc, mon_e.fdata);
                        end
                    end
                end
            end
            if (err) begin
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("FAIL unexpected_err actual 1 required 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    logic [FLIT_WIDTH-1:0] pk [2][2];
    logic [VC_WIDTH-1:0]   first_vc;
    logic [FLIT_WIDTH-1:0] f;

    initial begin
        checks  = 0;
        errors  = 0;
        exp_err = 0;
        arst    = 1'b1;
        fin_req = '0;
        set_rdy(4'h0);

        // Reset state
        tick(2);
        @(negedge clk);
        chk("rst_ready", 64'(fin_resp.ready), 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        chk("rst_fout_valid", 64'(valids()), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("post_rst_ready", 64'(fin_resp.ready), 64'd1);

        // Single-flit packet to the local port
        set_rdy(4'b0001);
        f = mk_head(2'd1, 2'd1, 8'd1, 18'h0A1);
        expect_out(0, 1'b0, f);
        push(1'b0, f);
        chk("single_valids", 64'(valids()), 64'b0001);
        chk("single_vc", 64'(fout_req[0].vc_id), 64'd0);
        chk("single_data", 64'(fout_req[0].fdata), 64'(f));
        chk("single_err", 64'(err), 64'd0);
        tick(3);

        // 4-flit packet east on VC1 with EAST stalled for 3 cycles
        set_rdy(4'b0000);
        pk[0][0] = mk_head(2'd3, 2'd1, 8'd4, 18'h0B0);
        pk[0][1] = mk_data(BODY_FLIT, 30'h0B1);
        pk[1][0] = mk_data(BODY_FLIT, 30'h0B2);
        pk[1][1] = mk_data(TAIL_FLIT, 30'h0B3);
        expect_out(3, 1'b1, pk[0][0]);
        expect_out(3, 1'b1, pk[0][1]);
        expect_out(3, 1'b1, pk[1][0]);
        expect_out(3, 1'b1, pk[1][1]);
        push(1'b1, pk[0][0]);
        chk("east_head_valids", 64'(valids()), 64'b1000);
        chk("east_head_vc", 64'(fout_req[3].vc_id), 64'd1);
        fork
            begin
                push(1'b1, pk[0][1]);
                push(1'b1, pk[1][0]);
                push(1'b1, pk[1][1]);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    tick(1);
                    chk("stall_valid", 64'(fout_req[3].valid), 64'd1);
                    chk("stall_data", 64'(fout_req[3].fdata), 64'(pk[0][0]));
                end
                set_rdy(4'b1000);
            end
        join
        tick(6);
        // VC1 must be IDLE again: a single flit to local now routes to slot 0
        set_rdy(4'b0001);
        f = mk_head(2'd1, 2'd1, 8'd1, 18'h0C0);
        expect_out(0, 1'b1, f);
        push(1'b1, f);
        chk("idle_again_valids", 64'(valids()), 64'b0001);
        tick(3);

        // Priority between two VCs heading east
        set_rdy(4'b0000);
        pk[0][0] = mk_head(2'd2, 2'd1, 8'd2, 18'h0D0);
        pk[0][1] = mk_data(TAIL_FLIT, 30'h0D1);
        pk[1][0] = mk_head(2'd3, 2'd1, 8'd2, 18'h0E0);
        pk[1][1] = mk_data(TAIL_FLIT, 30'h0E1);
        first_vc = H_PRIORITY ? 1'b1 : 1'b0;
        expect_out(3, first_vc, pk[first_vc][0]);
        expect_out(3, first_vc, pk[first_vc][1]);
        expect_out(3, ~first_vc, pk[~first_vc][0]);
        expect_out(3, ~first_vc, pk[~first_vc][1]);
        push(1'b0, pk[0][0]);
        push(1'b0, pk[0][1]);
        push(1'b1, pk[1][0]);
        push(1'b1, pk[1][1]);
        chk("prio_winner", 64'(fout_req[3].vc_id), 64'(first_vc));
        set_rdy(4'b1000);
        tick(8);

        // Full VC0 and a push rejected while a pop happens
        set_rdy(4'b0000);
        pk[0][0] = mk_head(2'd3, 2'd1, 8'd4, 18'h0F0);
        pk[0][1] = mk_data(BODY_FLIT, 30'h0F1);
        pk[1][0] = mk_data(BODY_FLIT, 30'h0F2);
        pk[1][1] = mk_data(TAIL_FLIT, 30'h0F3);
        expect_out(3, 1'b0, pk[0][0]);
        expect_out(3, 1'b0, pk[0][1]);
        expect_out(3, 1'b0, pk[1][1]);
        push(1'b0, pk[0][0]);
        push(1'b0, pk[0][1]);
        fin_req.vc_id = 1'b0;
        #1;
        chk("full_vc0_ready", 64'(fin_resp.ready), 64'd0);
        fin_req.vc_id = 1'b1;
        #1;
        chk("vc1_ready", 64'(fin_resp.ready), 64'd1);
        fin_req.vc_id = 1'b0;
        fin_req.fdata = pk[1][0];
        fin_req.valid = 1'b1;
        set_rdy(4'b1000);
        #1;
        chk("full_pop_ready", 64'(fin_resp.ready), 64'd0);
        chk("full_pop_valid", 64'(fout_req[3].valid), 64'd1);
        @(posedge clk);
        #1;
        fin_req.valid = 1'b0;
        push(1'b0, pk[1][1]);
        tick(6);

        // U-turn packet (destination west) and an orphan tail
        set_rdy(4'b1111);
        exp_err = exp_err + 3;
        push(1'b0, mk_head(2'd0, 2'd1, 8'd3, 18'h110));
        chk("uturn_err", 64'(err), 64'd1);
        chk("uturn_valids", 64'(valids()), 64'd0);
        push(1'b0, mk_data(BODY_FLIT, 30'h111));
        push(1'b0, mk_data(TAIL_FLIT, 30'h112));
        tick(3);
        exp_err = exp_err + 1;
        push(1'b1, mk_data(TAIL_FLIT, 30'h120));
        chk("orphan_err", 64'(err), 64'd1);
        chk("orphan_valids", 64'(valids()), 64'd0);
        tick(3);
        set_rdy(4'b0000);

`ifdef RAVENOC_IN_STATS_EN
        arst = 1'b1;
        tick(1);
        arst = 1'b0;
        set_rdy(4'b0001);
        for (int i = 0; i < 3; i++) begin
            f = mk_head(2'd1, 2'd1, 8'd1, 18'(32'h130 + i));
            expect_out(0, 1'b0, f);
            push(1'b0, f);
        end
        tick(3);
        chk("pkt_cnt_three", 64'(pkt_cnt), 64'd3);
        set_rdy(4'b0000);
`endif

        // Reset in the middle of a locked packet
        push(1'b1, mk_head(2'd3, 2'd1, 8'd3, 18'h140));
        push(1'b1, mk_data(BODY_FLIT, 30'h141));
        arst = 1'b1;
        fin_req.vc_id = 1'b1;
        #1;
        chk("midrst_ready", 64'(fin_resp.ready), 64'd0);
        tick(1);
        arst = 1'b0;
        #1;
        chk("midrst_valids", 64'(valids()), 64'd0);
        chk("midrst_ready_after", 64'(fin_resp.ready), 64'd1);
`ifdef RAVENOC_IN_STATS_EN
        chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        set_rdy(4'b0001);
        f = mk_head(2'd1, 2'd1, 8'd1, 18'h150);
        expect_out(0, 1'b1, f);
        push(1'b1, f);
        chk("midrst_local_valids", 64'(valids()), 64'b0001);
        tick(5);

        for (int k = 0; k < 4; k++)
            chk($sformatf("drain_slot%0d", k), 64'(exp_q[k].size()), 64'd0);
        chk("drain_err", 64'(exp_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
